uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
Serial UART receiver that deserialises an asynchronous 8N1 line and writes each valid byte into the downstream 4-entry receive FIFO (8-bit data, edge-triggered push, full flag). It sits between the board RX pin and the RX FIFO read by the 68k bus interface. It detects framing and overrun errors and reports them as sticky flags for the status register.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range 8..65535
CNT_W, 16, width of bit-timing counter; must hold CLKS_PER_BIT-1

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
rx  in  1  raw asynchronous serial input, idle high
fifo_full  in  1  downstream FIFO full flag
fifo_data  out  8  received byte, LSB = first data bit
fifo_push  out  1  one-cycle write strobe to FIFO push
busy  out  1  high while a frame is being received (state != IDLE)
frame_err  out  1  sticky: stop bit sampled low
overrun_err  out  1  sticky: valid byte dropped because fifo_full
err_clr  in  1  synchronous clear of both sticky flags

Behaviour:
- One clock. Reset is asynchronous and active-low: reset_n low clears all state immediately, independent of clk.
- Reset values: fifo_data=0, fifo_push=0, busy=0, frame_err=0, overrun_err=0, state=IDLE, counters=0; synchroniser flops reset to 1 (idle line).
- rx passes through a 2-flop synchroniser; the falling edge is detected on the synchronised signal (rx_s). Input latency: 2 cycles.
- Majority sample: rx_s is taken at counter values HALF-1, HALF and HALF+1, where HALF = CLKS_PER_BIT/2 (integer). The bit value is the majority of the three, decided at HALF+1.
- States:
  - IDLE: falling edge of rx_s -> START, counter=0.
  - START: counter runs. At the majority decision: if 1 (glitch), return to IDLE with no flags set. If 0, continue. At counter=CLKS_PER_BIT-1 -> DATA, bit_idx=0, counter=0.
  - DATA: majority bit is shifted into shift_reg at bit position bit_idx (LSB first). At counter=CLKS_PER_BIT-1, increment bit_idx; after bit 7 -> STOP.
  - STOP: at the majority decision:
    - Value 1 and fifo_full=0: fifo_data<=shift_reg, fifo_push=1 for exactly the next cycle, -> IDLE.
    - Value 1 and fifo_full=1: byte discarded, overrun_err<=1, no push, -> IDLE.
    - Value 0: frame_err<=1, byte discarded, -> BREAK.
    - STOP exits at mid-bit so the next start edge is not missed.
  - BREAK: wait until rx_s=1, then -> IDLE. A held-low line produces exactly one frame_err and no bytes.
- fifo_push is a single-cycle pulse. fifo_data is valid in the push cycle and held until the next accepted byte. The FIFO push input is edge-detected; back-to-back bytes are at least 9.5 bit times apart, so push always returns low between strobes.
- fifo_full is sampled only in the STOP decision cycle.
- err_clr clears both sticky flags. If err_clr and a new error coincide in the same cycle, the set wins.
- busy is combinational from state != IDLE.
- Counter arithmetic is unsigned CNT_W bits and never wraps: it is cleared on every bit boundary.
- reset_n asserted mid-frame aborts the frame. No push occurs, and the next valid start edge is received normally.

Decomposition:
- Package uart_pkg: state encoding (IDLE, START, DATA, STOP, BREAK; 3 bits), DATA_BITS=8, default CLKS_PER_BIT. These are shared with the future uart_tx_ser.
- Sub-module uart_rx_sync: 2-flop synchroniser plus falling-edge detector. Outputs rx_s and rx_fall. Same async active-low reset, resets to 1.

Test Plan (CLKS_PER_BIT=16):
- Frame 0xA5, stop=1, fifo_full=0 -> one fifo_push pulse, fifo_data=0xA5, no flags, busy low afterwards.
- Bytes 0x55 then 0x0F back-to-back (no idle gap) -> two separate pushes with data 0x55 and 0x0F; push low between them.
- 0x3C with stop bit forced 0 -> no push, frame_err=1. Then hold rx low for 30 bits -> still a single frame_err, no push. Then err_clr -> frame_err=0.
- fifo_full=1 during 0x81 -> no push, overrun_err=1. fifo_full=0 and 0x7E -> push 0x7E, overrun_err stays 1.
- rx low pulse of 3 cycles in IDLE -> returns to IDLE, no push, no flags. Single-cycle glitch inside a data bit of 0xFF -> majority keeps the byte at 0xFF.
- reset_n low for 1 cycle mid DATA of 0x12, then a full 0x34 frame -> only 0x34 pushed; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry, default
// bit timing and the three-sample majority vote used by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Two-out-of-three vote; rejects a single-sample glitch.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw rx pin plus a falling-edge detector
// on the synchronised line. Flops reset to 1 so reset looks like idle.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic rx_meta;
  logic rx_sync_q;
  logic rx_sync_d;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta   <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync_q <= rx_meta;
      rx_sync_d <= rx_sync_q;
    end
  end

  assign rx_s    = rx_sync_q;
  assign rx_fall = rx_sync_d & ~rx_sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver. Each bit is decided by a majority vote of three
// samples around mid-bit; good bytes are strobed into the RX FIFO,
// framing and overrun errors are kept as sticky status flags.
//
// FIFO handshake: fifo_push is a one-cycle strobe with fifo_data valid in
// that same cycle. There is no back-pressure stall: fifo_full is looked at
// only when the stop bit is decided, and a byte that finds the FIFO full
// is dropped and recorded in overrun_err.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic              fifo_full,
  output logic [7:0]        fifo_data,
  output logic              fifo_push,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun_err,
  input  logic              err_clr,
  output uart_state_e       state_dbg
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  uart_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             samp_a;
  logic             samp_b;
  logic             rx_s;
  logic             rx_fall;
  logic             vote;
  logic             decide;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  assign vote      = majority3(samp_a, samp_b, rx_s);
  assign decide    = (cnt == DECIDE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // Receive FSM: bit timing, sampling, byte assembly, push and error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      samp_a      <= 1'b1;
      samp_b      <= 1'b1;
      fifo_data   <= '0;
      fifo_push   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      fifo_push <= 1'b0;
      // Clear first so a coinciding error set below takes priority.
      if (err_clr) begin
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (cnt == SAMP_A) samp_a <= rx_s;
      if (cnt == SAMP_B) samp_b <= rx_s;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_fall) state <= ST_START;
        end
        ST_START: begin
          if (decide && vote) begin
            // Start bit did not hold low: treat as noise.
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == BIT_LAST) begin
            state   <= ST_DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (decide) shift_reg[bit_idx] <= vote;
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (bit_idx == IDX_LAST) state <= ST_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          // Leave at mid stop bit so an immediately following start edge is seen.
          if (decide) begin
            cnt <= '0;
            if (vote) begin
              state <= ST_IDLE;
              if (!fifo_full) begin
                fifo_data <= shift_reg;
                fifo_push <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser at 16 clocks per bit: directed frames followed by
// random frames, checked against a frame-level model of expected bytes and
// sticky flags.
module tb_uart_rx_deser;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        fifo_full = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  fifo_data;
  logic        fifo_push;
  logic        busy;
  logic        frame_err;
  logic        overrun_err;
  uart_state_e state_dbg;

  uart_rx_deser #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .fifo_full   (fifo_full),
    .fifo_data   (fifo_data),
    .fifo_push   (fifo_push),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .err_clr     (err_clr),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       m_frame_err = 1'b0;
  logic       m_overrun   = 1'b0;
  logic       prev_push   = 1'b0;
  int         push_cnt    = 0;
  int         first_push_cyc = -1;
  logic [7:0] exp_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle out of reset: pushes must match the expected byte queue,
  // never repeat on consecutive cycles, and fifo_data must hold the last byte.
  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_push) begin
        check("push_not_back_to_back", {31'd0, prev_push}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_push", 32'd1, 32'd0);
        end else begin
          exp_byte = exp_q.pop_front();
          check("push_data", {24'd0, fifo_data}, {24'd0, exp_byte});
          last_data = exp_byte;
        end
        push_cnt++;
        if (first_push_cyc < 0) first_push_cyc = cyc;
      end
      check("data_hold", {24'd0, fifo_data}, {24'd0, last_data});
      prev_push = fifo_push;
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic b, input logic glitch);
    for (int c = 0; c < CPB; c++) begin
      rx = (glitch && c == CPB / 2) ? ~b : b;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, 1'b0);
  endtask

  // Sends one 8N1 frame; glitch_bit selects a data bit with a 1-cycle flip.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic full,
                            input int glitch_bit);
    fifo_full = full;
    if (stop && !full) exp_q.push_back(d);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == glitch_bit));
    drive_bit(stop, 1'b0);
    if (!stop) m_frame_err = 1'b1;
    else if (full) m_overrun = 1'b1;
  endtask

  task automatic end_frame(input string tag, input logic stop);
    check({tag, "_push_done"}, exp_q.size(), 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, {31'd0, m_frame_err});
    check({tag, "_overrun_err"}, {31'd0, overrun_err}, {31'd0, m_overrun});
    if (stop) check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_frame_err = 1'b0;
    m_overrun   = 1'b0;
    check("err_clr_frame", {31'd0, frame_err}, 32'd0);
    check("err_clr_overrun", {31'd0, overrun_err}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'd0, fifo_data}, 32'd0);
    check({tag, "_push"}, {31'd0, fifo_push}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun_err}, 32'd0);
    check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
  endtask

  // ---------------- main sequence ----------------
  int start_cyc;
  int pushes_before;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle_bits(2);

    // Single clean frame; first push lands 157 cycles after the start edge.
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    end_frame("a5", 1'b1);
    check("push_latency", first_push_cyc - start_cyc, 32'd157);
    check("fifo_data_a5", {24'd0, fifo_data}, 32'h0000_00A5);
    idle_bits(1);

    // Back-to-back frames without an idle gap.
    send_frame(8'h55, 1'b1, 1'b0, -1);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    end_frame("b2b", 1'b1);
    check("fifo_data_0f", {24'd0, fifo_data}, 32'h0000_000F);
    idle_bits(1);

    // Framing error, then a long break: exactly one error, no bytes.
    pushes_before = push_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    check("frame_err_set", {31'd0, frame_err}, 32'd1);
    rx = 1'b0;
    repeat (30 * CPB) @(posedge clk);
    #1;
    check("break_busy", {31'd0, busy}, 32'd1);
    idle_bits(2);
    end_frame("break", 1'b1);
    check("break_no_push", push_cnt - pushes_before, 32'd0);
    clear_errors();

    // Overrun on a full FIFO, then a good byte leaves the flag set.
    send_frame(8'h81, 1'b1, 1'b1, -1);
    end_frame("overrun", 1'b1);
    check("overrun_set", {31'd0, overrun_err}, 32'd1);
    idle_bits(1);
    send_frame(8'h7E, 1'b1, 1'b0, -1);
    end_frame("after_overrun", 1'b1);
    check("overrun_sticky", {31'd0, overrun_err}, 32'd1);
    clear_errors();
    idle_bits(1);

    // Short low pulse in idle is rejected as a false start.
    pushes_before = push_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    idle_bits(2);
    end_frame("false_start", 1'b1);
    check("false_start_no_push", push_cnt - pushes_before, 32'd0);

    // One-cycle glitch in the middle of a data bit is voted out.
    send_frame(8'hFF, 1'b1, 1'b0, 3);
    end_frame("glitch", 1'b1);
    check("fifo_data_ff", {24'd0, fifo_data}, 32'h0000_00FF);
    idle_bits(1);

    // Reset in the middle of a frame aborts it.
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    for (int c = 0; c < CPB / 2; c++) begin
      rx = 1'b1;
      @(posedge clk); #1;
    end
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    rx = 1'b1;
    last_data = 8'h00;
    m_frame_err = 1'b0;
    m_overrun = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_bits(2);
    send_frame(8'h34, 1'b1, 1'b0, -1);
    end_frame("after_reset", 1'b1);
    check("fifo_data_34", {24'd0, fifo_data}, 32'h0000_0034);
    idle_bits(1);

    // Random frames: random data, stop bit, FIFO full, gaps and clears.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       stop;
      logic       full;
      int         gap;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      full = ($urandom_range(0, 4) == 0);
      gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      if ($urandom_range(0, 5) == 0) clear_errors();
      send_frame(d, stop, full, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1);
      end_frame("rand", stop);
      idle_bits(gap);
    end
    fifo_full = 1'b0;
    idle_bits(2);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
